conv_accumulator: RTL and testbench
===================================

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 SHALL have parameter TAPS, default 9, meaning products summed per window (legal range 1..16).
REQ-002 SHALL have parameter DW, default 8, meaning product input width (4-bit x 4-bit multiplier result).
REQ-003 SHALL have parameter OW, default 12, meaning result width (16 x 225 = 3600 fits).
REQ-004 SHALL have port clk, input, 1, meaning single rising-edge clock.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port Start, input, 1, meaning window enable, the same Start that gates the upstream multiplier.
REQ-007 SHALL have port din, input, DW, meaning unsigned product (image x filter) from the multiplier stage.
REQ-008 SHALL have port in_valid, input, 1, meaning din is a valid product this cycle.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts din this cycle.
REQ-010 SHALL have port dout, output, OW, meaning completed window sum.
REQ-011 SHALL have port out_valid, output, 1, meaning dout holds a completed sum.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes dout this cycle.
REQ-013 SHALL have port tap_cnt, output, 4, meaning products accepted so far in the current window.

Function
REQ-014 SHALL implement states IDLE, ACC and HOLD.
REQ-015 SHALL, in IDLE with Start=1, clear the accumulator and tap_cnt and enter ACC on the next edge.
REQ-016 SHALL drive in_ready=1 only in ACC, and 0 in IDLE and HOLD.
REQ-017 SHALL count a transfer in ACC only when in_valid=1 and in_ready=1; a cycle with in_valid=0 leaves the accumulator and tap_cnt unchanged.
REQ-018 SHALL, on each transfer, add din zero-extended to OW bits and increment tap_cnt.
REQ-019 SHALL, on the transfer that makes tap_cnt reach TAPS, load dout with the full sum, set out_valid=1, reset tap_cnt to 0 and enter HOLD; dout is valid one cycle after the last transfer.
REQ-020 SHALL hold dout and out_valid stable in HOLD until out_ready=1.
REQ-021 SHALL, in HOLD with out_ready=1, drop out_valid on the next edge and go to ACC (accumulator cleared) if Start=1, otherwise to IDLE.
REQ-022 SHALL abort when Start=0 in ACC: discard the partial sum, clear tap_cnt and return to IDLE with out_valid=0.
REQ-023 SHALL ignore Start in HOLD; a pending result is never discarded.
REQ-024 SHALL never overflow the accumulator, given legal TAPS and DW.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and set dout=0, out_valid=0, in_ready=0, tap_cnt=0 and accumulator=0, in any state.
REQ-026 SHALL give rst priority over every other input, including mid-window and in HOLD.

Structure
REQ-027 SHALL take TAPS, DW and OW defaults and the state encoding from shared package conv_pkg.
REQ-028 SHALL contain one sub-module, tap_counter (clear, enable, terminal-count flag at TAPS).

Verification
REQ-029 SHALL test: Start=1, 9 back-to-back products of 225, out_ready=1 -> dout=2025 (0x7E9) with out_valid one cycle after the 9th transfer.
REQ-030 SHALL test: products 1..9 with in_valid low on alternate cycles -> dout=45, and tap_cnt freezes during the gaps.
REQ-031 SHALL test: window completes with out_ready=0 for 5 cycles -> dout and out_valid stable and in_ready=0 throughout; result accepted on the 6th cycle.
REQ-032 SHALL test: Start dropped after 4 products -> IDLE, no out_valid; the next window of nine 10s -> dout=90 with no carry-over.
REQ-033 SHALL test: rst pulsed after 5 products, then in HOLD -> all outputs 0 and state IDLE on the following cycle.
REQ-034 SHALL test: Start held high across two windows with out_ready=1 -> two sums with no IDLE cycle between them.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and state encoding for the convolution accumulator slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Default geometry: 9 taps of 4b x 4b products (max 225), 12-bit sums (max 2025).
    localparam int TAPS_DEF = 9;
    localparam int DW_DEF   = 8;
    localparam int OW_DEF   = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage : conv_pkg

// File: rtl/conv_accumulator_tap_counter.sv
// Window tap counter: counts accepted products and flags the one that completes a window.
// Latency: count updates on the edge after i_en; o_last is combinational from i_en.
// Backpressure: none; the parent gates i_en with its own handshake.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - clear count to zero (wins over i_en)
//   i_en      - one product accepted this cycle
//   o_cnt     - products accepted so far in the current window
//   o_last    - this cycle's accepted product is number TAPS of the window
module tap_counter #(
    parameter int TAPS = conv_pkg::TAPS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [3:0] o_cnt,
    output logic       o_last
);

    localparam logic [3:0] LAST_CNT = 4'(TAPS - 1);

    logic [3:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = i_en && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Wrap to zero on the terminal product so the count never has to reach 16.
            r_cnt <= o_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

endmodule : tap_counter

// File: rtl/conv_accumulator.sv
// Sums TAPS unsigned products per window and presents the total on a valid/ready output.
// Latency: dout/out_valid are registered, valid one cycle after the last product is accepted.
// Backpressure: in_ready drops while a result waits in HOLD; the result is held until out_ready.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset (highest priority)
//   Start                - window enable; low during accumulation aborts the window
//   din/in_valid/in_ready  - product input handshake (in_ready high only while accumulating)
//   dout/out_valid/out_ready - completed window sum handshake
//   tap_cnt              - products accepted so far in the current window
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int OW   = OW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    tap_cnt
);

    state_t        r_state;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] r_dout;
    logic          r_out_valid;
    logic          r_in_ready;

    logic          w_xfer;
    logic          w_last;
    logic          w_clr;
    logic [OW-1:0] w_sum;

    // An abort (Start low) takes precedence over a product offered in the same cycle.
    assign w_xfer = (r_state == ST_ACC) && Start && in_valid && r_in_ready;
    // Outside an active window the count is held at zero, so every window starts clean.
    assign w_clr  = !((r_state == ST_ACC) && Start);
    assign w_sum  = r_acc + {{(OW-DW){1'b0}}, din};

    tap_counter #(
        .TAPS (TAPS)
    ) u_tap_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_xfer),
        .o_cnt  (tap_cnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_acc      <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (!Start) begin
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_dout      <= w_sum;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc <= w_sum;
                        end
                    end
                end
                ST_HOLD: begin
                    // Start is deliberately ignored until the pending result is taken.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_in_ready  <= Start;
                        r_state     <= Start ? ST_ACC : ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign dout      = r_dout;
    assign out_valid = r_out_valid;

endmodule : conv_accumulator

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed windows followed by random traffic.
// Latency: n/a.
// Backpressure: out_ready is driven directly and randomised in the random phase.
module tb_conv_accumulator;

    localparam int TAPS = 9;
    localparam int DW   = 8;
    localparam int OW   = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] dout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    tap_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = accumulating, 2 = holding a result.
    int mode = 0;
    int win[$];
    int m_dout = 0;
    bit m_ov = 1'b0;

    always #5 clk = ~clk;

    conv_accumulator #(
        .TAPS (TAPS),
        .DW   (DW),
        .OW   (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tap_cnt   (tap_cnt)
    );

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit v, input int d, input bit o);
        if (r) begin
            mode = 0; win.delete(); m_dout = 0; m_ov = 1'b0;
        end else begin
            case (mode)
                0: if (s) begin win.delete(); mode = 1; end
                1: begin
                    if (!s) begin
                        win.delete(); mode = 0;
                    end else if (v) begin
                        win.push_back(d);
                        if (win.size() == TAPS) begin
                            m_dout = win_sum(); m_ov = 1'b1; win.delete(); mode = 2;
                        end
                    end
                end
                default: if (o) begin
                    m_ov = 1'b0; win.delete(); mode = s ? 1 : 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        cmp("in_ready",  32'(in_ready),  32'(mode == 1));
        cmp("tap_cnt",   32'(tap_cnt),   32'(win.size()));
        cmp("out_valid", 32'(out_valid), 32'(m_ov));
        cmp("dout",      32'(dout),      32'(m_dout));
    endtask

    // Drive inputs at the falling edge, let one rising edge happen, check at the next falling edge.
    task automatic step(input bit r, input bit s, input bit v, input int d, input bit o);
        rst = r; Start = s; in_valid = v; din = DW'(d); out_ready = o;
        @(posedge clk);
        model_edge(r, s, v, d, o);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int frozen;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 99, 1);
        cmp("rst_dout", 32'(dout), 0);
        cmp("rst_ov", 32'(out_valid), 0);

        // Nine back-to-back 225s -> 2025, valid one cycle after the 9th transfer
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < TAPS; i++) begin
            step(0, 1, 1, 225, 1);
            if (i == TAPS - 2) cmp("max_ov_early", 32'(out_valid), 0);
        end
        cmp("max_dout", 32'(dout), 2025);
        cmp("max_ov", 32'(out_valid), 1);

        // Consume and continue straight into the next window
        step(0, 1, 0, 0, 1);
        // Products 1..9 with gaps; tap_cnt must freeze during gaps
        for (int i = 1; i <= TAPS; i++) begin
            step(0, 1, 1, i, 1);
            if (i < TAPS) begin
                frozen = int'(tap_cnt);
                step(0, 1, 0, $urandom_range(0, 255), 1);
                cmp("gap_freeze", 32'(tap_cnt), 32'(frozen));
            end
        end
        cmp("gap_dout", 32'(dout), 45);

        // Window completes under backpressure: stable for 5 cycles, taken on the 6th
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < TAPS; i++) step(0, 1, 1, 7 * i + 3, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, $urandom_range(0, 1), 1, 200, 0);
            cmp("bp_dout", 32'(dout), 3 * 9 + 7 * 36);
            cmp("bp_ov", 32'(out_valid), 1);
            cmp("bp_inrdy", 32'(in_ready), 0);
        end
        step(0, 0, 0, 0, 1);
        cmp("bp_taken", 32'(out_valid), 0);

        // Abort after 4 products, then a clean window of nine 10s
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 50, 0);
        step(0, 0, 1, 50, 0);
        cmp("abort_ov", 32'(out_valid), 0);
        cmp("abort_cnt", 32'(tap_cnt), 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) step(0, 1, 1, 10, 0);
        cmp("abort_next", 32'(dout), 90);
        step(0, 0, 0, 0, 1);

        // Reset mid-window and in HOLD
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 30, 0);
        step(1, 1, 1, 30, 0);
        cmp("rst_mid_cnt", 32'(tap_cnt), 0);
        cmp("rst_mid_rdy", 32'(in_ready), 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) step(0, 1, 1, 20, 0);
        cmp("rst_hold_pre", 32'(out_valid), 1);
        step(1, 1, 1, 20, 0);
        cmp("rst_hold_dout", 32'(dout), 0);
        cmp("rst_hold_ov", 32'(out_valid), 0);
        step(0, 0, 0, 0, 0);
        cmp("rst_idle_rdy", 32'(in_ready), 0);

        // Two windows with Start held high: no idle cycle in between
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < TAPS; i++) step(0, 1, 1, 100, 1);
        cmp("two_first", 32'(dout), 900);
        step(0, 1, 0, 0, 1);
        cmp("two_noidle", 32'(in_ready), 1);
        for (int i = 0; i < TAPS; i++) step(0, 1, 1, 200, 1);
        cmp("two_second", 32'(dout), 1800);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 255),
                 $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_conv_accumulator
